// File: rtl/am_class_streamer.sv
// am_class_streamer
// Reads class hypervectors out of the class-HV SRAM in linear order
// (segment-major, class-minor) and hands them to the associative memory
// over a valid/ready port. A small output FIFO absorbs the 1-cycle SRAM
// read latency so that the stream runs at one HV per cycle when the
// consumer keeps ready high. Requests are only issued when a slot is
// guaranteed to be free by the time the read data comes back.

module am_class_streamer #(
   parameter int unsigned HVDimension = 512,
   parameter int unsigned DataWidth   = 8,
   parameter int unsigned AddrWidth   = 10,
   parameter int unsigned FifoDepth   = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic                   abort_i,
   output logic                   busy_o,
   output logic                   done_o,
   input  logic [DataWidth-1:0]   num_class_i,
   input  logic                   extend_enable_i,
   input  logic [4:0]             extend_count_i,
   input  logic [AddrWidth-1:0]   base_addr_i,
   output logic                   mem_req_o,
   output logic [AddrWidth-1:0]   mem_addr_o,
   input  logic [HVDimension-1:0] mem_rdata_i,
   output logic [HVDimension-1:0] class_hv_o,
   output logic                   class_hv_valid_o,
   input  logic                   class_hv_ready_i
);

   // Transfer counters must hold num_class * 31 segments.
   localparam int unsigned CntW = DataWidth + 5;
   // FIFO read/write pointer width.
   localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   // Occupancy width, one spare bit so fifo_cnt + inflight never overflows.
   localparam int unsigned OccW = $clog2(FifoDepth + 1) + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   // Stream configuration captured at start.
   logic [CntW-1:0]        r_total;
   logic [AddrWidth-1:0]   r_base;

   // Progress counters.
   logic [CntW-1:0]        r_issued;
   logic [CntW-1:0]        r_popped;
   logic                   r_inflight;
   logic                   r_zero_done;

   // Output FIFO.
   logic [HVDimension-1:0] r_fifo_mem [FifoDepth];
   logic [PtrW-1:0]        r_wr_ptr;
   logic [PtrW-1:0]        r_rd_ptr;
   logic [OccW-1:0]        r_fifo_cnt;

   // Combinational helpers.
   logic [4:0]             w_eff_seg;
   logic [CntW-1:0]        w_start_total;
   logic                   w_start_go;
   logic                   w_start_zero;
   logic                   w_fifo_valid;
   logic                   w_pop;
   logic                   w_push;
   logic [OccW-1:0]        w_occ;
   logic                   w_room;
   logic                   w_mem_req;
   logic [CntW-1:0]        w_popped_inc;

   // Advance a FIFO pointer, wrapping at the configured depth.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      if (p == PtrW'(FifoDepth - 1)) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   // Segment count: expansion only counts when enabled with a non-zero count.
   assign w_eff_seg     = (extend_enable_i && (extend_count_i != 5'd0)) ? extend_count_i : 5'd1;
   assign w_start_total = CntW'(num_class_i) * CntW'(w_eff_seg);

   assign w_start_go    = (r_state == ST_IDLE) && start_i && !abort_i && (w_start_total != '0);
   assign w_start_zero  = (r_state == ST_IDLE) && start_i && !abort_i && (w_start_total == '0);

   assign w_fifo_valid  = (r_fifo_cnt != '0);
   assign w_pop         = w_fifo_valid && class_hv_ready_i;
   // Read data for an aborted stream is dropped on the floor.
   assign w_push        = r_inflight && !abort_i;

   // Occupancy the FIFO will have once this cycle's pop and the in-flight
   // read have both landed; a new request is only safe if that leaves room.
   assign w_occ         = r_fifo_cnt
                        + {{(OccW-1){1'b0}}, r_inflight}
                        - {{(OccW-1){1'b0}}, w_pop};
   assign w_room        = (w_occ < OccW'(FifoDepth));

   assign w_popped_inc  = r_popped + 1'b1;

   // Next-state and request generation.
   always_comb begin
      w_state_next = r_state;
      w_mem_req    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start_go) begin
               w_state_next = ST_STREAM;
            end
         end
         ST_STREAM: begin
            w_mem_req = (r_issued < r_total) && w_room;
            if (abort_i) begin
               w_state_next = ST_IDLE;
            end else if (w_pop && (w_popped_inc == r_total)) begin
               w_state_next = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
      if (abort_i) begin
         w_state_next = ST_IDLE;
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Stream configuration, issue/pop counters and the in-flight flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_total     <= '0;
         r_base      <= '0;
         r_issued    <= '0;
         r_popped    <= '0;
         r_inflight  <= 1'b0;
         r_zero_done <= 1'b0;
      end else if (abort_i) begin
         r_issued    <= '0;
         r_popped    <= '0;
         r_inflight  <= 1'b0;
         r_zero_done <= 1'b0;
      end else begin
         r_zero_done <= w_start_zero;
         r_inflight  <= w_mem_req;
         if (w_start_go) begin
            r_total  <= w_start_total;
            r_base   <= base_addr_i;
            r_issued <= '0;
            r_popped <= '0;
         end else begin
            if (w_mem_req) begin
               r_issued <= r_issued + 1'b1;
            end
            if (w_pop) begin
               r_popped <= w_popped_inc;
            end
         end
      end
   end

   // FIFO pointers and occupancy; abort empties the buffer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fifo_cnt <= '0;
      end else if (abort_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fifo_cnt <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
            2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

   // FIFO storage; contents are only observable while the entry is valid,
   // so the wide data array needs no reset.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fifo_mem[r_wr_ptr] <= mem_rdata_i;
      end
   end

   assign busy_o           = (r_state != ST_IDLE);
   assign done_o           = (r_state == ST_FLUSH) || r_zero_done;
   assign mem_req_o        = w_mem_req;
   assign mem_addr_o       = r_base + AddrWidth'(r_issued);
   assign class_hv_valid_o = w_fifo_valid;
   // Head is masked while empty so the port reads zero out of reset.
   assign class_hv_o       = w_fifo_valid ? r_fifo_mem[r_rd_ptr] : '0;

endmodule
